// File: rtl/adc_serial_if.sv
// Three-wire serial front end for an ADC128S022-compatible converter.
// Runs one 16-SCLK frame per accepted start (or back-to-back in continuous mode) and publishes result bits [11:4].
module adc_serial_if #(
    parameter int CLK_DIV = 2,
    parameter int QUIET   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic [2:0] chan,
    input  logic       adc_dout,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       adc_din,
    output logic [7:0] adc_sample,
    output logic       sample_valid,
    output logic       busy
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int QCNT_W = $clog2(QUIET + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [QCNT_W-1:0] QUIET_LAST = (QUIET >= 2) ? QCNT_W'(QUIET - 2) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE,
        ST_QUIET
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        edge_q, edge_d;
    logic [QCNT_W-1:0] quiet_q, quiet_d;
    logic [2:0]        chan_q, chan_d;
    logic [15:0]       shreg_q, shreg_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              din_q, din_d;
    logic [7:0]        sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic [3:0]        edge_nxt;
    logic [15:0]       frame_w;

    // NOTE: registers update with non-blocking assignments so every _q samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            edge_q   <= '0;
            quiet_q  <= '0;
            chan_q   <= '0;
            shreg_q  <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            din_q    <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            quiet_q  <= quiet_d;
            chan_q   <= chan_d;
            shreg_q  <= shreg_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            din_q    <= din_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        edge_d   = edge_q;
        quiet_d  = quiet_q;
        chan_d   = chan_q;
        shreg_d  = shreg_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        din_d    = din_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        edge_nxt = edge_q + 4'd1;
        frame_w  = {2'b00, chan_q, 11'b0};

        unique case (state_q)
            ST_IDLE: begin
                if (start || cont) begin
                    state_d = ST_SETUP;
                    chan_d  = chan;
                    div_d   = '0;
                    edge_d  = '0;
                    shreg_d = '0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = ST_SHIFT;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    din_d   = frame_w[15];
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    // adc_dout has been settling for a full half-period since our falling edge, so no synchroniser.
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        shreg_d = {shreg_q[14:0], adc_dout};
                    end else if (edge_q == 4'd15) begin
                        state_d  = ST_DONE;
                        cs_n_d   = 1'b1;
                        din_d    = 1'b0;
                        sample_d = shreg_q[11:4];
                        valid_d  = 1'b1;
                    end else begin
                        edge_d = edge_nxt;
                        sclk_d = 1'b0;
                        din_d  = frame_w[4'd15 - edge_nxt];
                    end
                end
            end

            // DONE is the first cs_n-high cycle of the inter-frame gap.
            ST_DONE: begin
                if (QUIET > 1) begin
                    state_d = ST_QUIET;
                    quiet_d = '0;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            ST_QUIET: begin
                if (quiet_q == QUIET_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    quiet_d = quiet_q + QCNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign adc_din      = din_q;
    assign adc_sample   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;

    a_sclk_idle_high: assert property (@(posedge clk) disable iff (!rst) adc_cs_n |-> adc_sclk);
    a_valid_outside_frame: assert property (@(posedge clk) disable iff (!rst) sample_valid |-> adc_cs_n && busy);

endmodule

// File: tb/tb_adc_serial_if.sv
// Scoreboard bench for adc_serial_if: two instances (CLK_DIV=2/QUIET=2 and CLK_DIV=5/QUIET=4) share the control inputs.
// A timing-level model predicts accepted frames; ADC models answer each frame and a monitor checks every sample.
module tb_adc_serial_if;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [2:0] chan = 3'd0;

    logic       dout  [2];
    logic       cs_n  [2];
    logic       sclk  [2];
    logic       din   [2];
    logic [7:0] sample[2];
    logic       valid [2];
    logic       busy  [2];

    adc_serial_if #(.CLK_DIV(2), .QUIET(2)) dut0 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .chan(chan), .adc_dout(dout[0]),
        .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .adc_din(din[0]), .adc_sample(sample[0]),
        .sample_valid(valid[0]), .busy(busy[0])
    );

    adc_serial_if #(.CLK_DIV(5), .QUIET(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .chan(chan), .adc_dout(dout[1]),
        .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .adc_din(din[1]), .adc_sample(sample[1]),
        .sample_valid(valid[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    function automatic int cd_of(input int i);
        return (i == 0) ? 2 : 5;
    endfunction

    function automatic int q_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    typedef struct {
        int         inst;
        int         t0;
        logic [7:0] smp;
        logic [2:0] ch;
        bit         b2b;
    } exp_t;

    typedef struct {
        int          inst;
        logic [11:0] v;
    } adc_t;

    exp_t        exp_q[$];
    adc_t        adc_q[$];
    logic [11:0] plan_q[$];
    int          free_at[2];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int find_exp(input int i);
        for (int k = 0; k < exp_q.size(); k++) if (exp_q[k].inst == i) return k;
        return -1;
    endfunction

    function automatic int find_adc(input int i);
        for (int k = 0; k < adc_q.size(); k++) if (adc_q[k].inst == i) return k;
        return -1;
    endfunction

    // Reference model: a frame accepted at cycle t0 ends with a sample at t0+1+33*CLK_DIV
    // and the block can accept again QUIET cycles later.
    always @(posedge clk) begin
        logic [11:0] v;
        if (!rst) begin
            exp_q.delete();
            adc_q.delete();
            free_at[0] = 0;
            free_at[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if ((start || cont) && cyc >= free_at[i]) begin
                    if (i == 0 && plan_q.size() > 0) v = plan_q.pop_front();
                    else v = 12'($urandom_range(0, 4095));
                    adc_q.push_back('{inst: i, v: v});
                    exp_q.push_back('{inst: i, t0: cyc, smp: v[11:4], ch: chan,
                                      b2b: (free_at[i] != 0 && cyc == free_at[i])});
                    free_at[i] = cyc + 1 + 33 * cd_of(i) + q_of(i);
                end
            end
        end
        cyc++;
    end

    logic [15:0] word     [2];
    logic [15:0] din_word [2];
    int          n_fall   [2];
    int          last_edge[2];
    int          cs_fall  [2];
    int          cs_rise  [2];
    int          gap      [2];
    bit          hp_bad   [2];
    logic        prev_cs  [2];
    logic        prev_sclk[2];
    logic [7:0]  last_smp [2];

    // ADC models and output monitor, sampled on the falling clk edge.
    always @(negedge clk) begin
        int   k;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                prev_cs[i]   = 1'b1;
                prev_sclk[i] = 1'b1;
                dout[i]      = 1'b0;
                last_smp[i]  = 8'h00;
                n_fall[i]    = 0;
                cs_rise[i]   = 0;
            end else begin
                if (prev_cs[i] && !cs_n[i]) begin
                    k = find_adc(i);
                    check($sformatf("inst%0d frame start was expected", i), int'(k >= 0), 1);
                    check($sformatf("inst%0d busy at cs_n fall", i), int'(busy[i]), 1);
                    if (k >= 0) begin
                        word[i] = {4'h0, adc_q[k].v};
                        adc_q.delete(k);
                    end else begin
                        word[i] = 16'h0000;
                    end
                    gap[i]       = cyc - cs_rise[i];
                    cs_fall[i]   = cyc;
                    last_edge[i] = cyc;
                    n_fall[i]    = 0;
                    din_word[i]  = 16'h0000;
                    hp_bad[i]    = 1'b0;
                end
                if (!prev_cs[i] && cs_n[i]) cs_rise[i] = cyc;
                if (!cs_n[i] && sclk[i] != prev_sclk[i]) begin
                    if (cyc - last_edge[i] != cd_of(i)) hp_bad[i] = 1'b1;
                    last_edge[i] = cyc;
                    if (!sclk[i]) begin
                        if (n_fall[i] < 16) dout[i] = word[i][15 - n_fall[i]];
                        n_fall[i]++;
                    end else begin
                        din_word[i] = {din_word[i][14:0], din[i]};
                    end
                end
                if (valid[i]) begin
                    k = find_exp(i);
                    if (k < 0) begin
                        check($sformatf("inst%0d sample_valid with no frame expected", i), 1, 0);
                    end else begin
                        e = exp_q[k];
                        exp_q.delete(k);
                        check($sformatf("inst%0d sample_valid cycle", i), cyc, e.t0 + 1 + 33 * cd_of(i));
                        check($sformatf("inst%0d adc_sample", i), int'(sample[i]), int'(e.smp));
                        check($sformatf("inst%0d din frame word", i), int'(din_word[i]), int'({2'b00, e.ch, 11'b0}));
                        check($sformatf("inst%0d sclk low pulses", i), n_fall[i], 16);
                        check($sformatf("inst%0d sclk half-period ok", i), int'(hp_bad[i]), 0);
                        check($sformatf("inst%0d cs_n fall cycle", i), cs_fall[i], e.t0 + 1);
                        check($sformatf("inst%0d cs_n/sclk high at valid", i), int'(cs_n[i] && sclk[i]), 1);
                        check($sformatf("inst%0d busy at valid", i), int'(busy[i]), 1);
                        if (e.b2b) check($sformatf("inst%0d cs_n high gap", i), gap[i], q_of(i) + 1);
                    end
                    last_smp[i] = sample[i];
                end else begin
                    check($sformatf("inst%0d adc_sample hold", i), int'(sample[i]), int'(last_smp[i]));
                end
                prev_cs[i]   = cs_n[i];
                prev_sclk[i] = sclk[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s inst%0d adc_cs_n", tag, i), int'(cs_n[i]), 1);
            check($sformatf("%s inst%0d adc_sclk", tag, i), int'(sclk[i]), 1);
            check($sformatf("%s inst%0d adc_din", tag, i), int'(din[i]), 0);
            check($sformatf("%s inst%0d adc_sample", tag, i), int'(sample[i]), 0);
            check($sformatf("%s inst%0d sample_valid", tag, i), int'(valid[i]), 0);
            check($sformatf("%s inst%0d busy", tag, i), int'(busy[i]), 0);
        end
    endtask

    initial begin
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        tick(3);

        // Single conversion on channel 5 with a known result.
        chan = 3'd5;
        plan_q.push_back(12'hA5C);
        start = 1'b1; tick(1); start = 1'b0;
        tick(200);

        // Starts at t=10 and at the DONE cycle (t=67) must be dropped.
        chan  = 3'd2;
        start = 1'b1; tick(1); start = 1'b0;
        tick(9);
        start = 1'b1; tick(1); start = 1'b0;
        tick(56);
        start = 1'b1; tick(1); start = 1'b0;
        tick(200);

        // Continuous mode, three frames on the fast instance; cont drops mid third frame.
        plan_q.push_back(12'h000);
        plan_q.push_back(12'hFFF);
        plan_q.push_back(12'h800);
        chan = 3'd7;
        cont = 1'b1; tick(150); cont = 1'b0;
        tick(300);

        // Channel 3 -> 6 at falling edge 8 of the fast instance's frame.
        chan  = 3'd3;
        start = 1'b1; tick(1); start = 1'b0;
        tick(34);
        chan = 3'd6;
        tick(50);
        start = 1'b1; tick(1); start = 1'b0;
        tick(200);

        // Random starts, channels and continuous bursts.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 15) == 0);
            chan  = 3'($urandom_range(0, 7));
            cont  = (n >= 1500 && n < 2000) || (n >= 2500 && n < 2600);
            tick(1);
        end
        start = 1'b0;
        cont  = 1'b0;
        tick(250);

        // Publish a non-zero sample, then reset 20 cycles into the next frame.
        plan_q.push_back(12'hFF3);
        start = 1'b1; tick(1); start = 1'b0;
        tick(100);
        chan  = 3'd1;
        start = 1'b1; tick(1); start = 1'b0;
        tick(19);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("mid-frame reset inst%0d adc_cs_n", i), int'(cs_n[i]), 1);
            check($sformatf("mid-frame reset inst%0d adc_sclk", i), int'(sclk[i]), 1);
            check($sformatf("mid-frame reset inst%0d busy", i), int'(busy[i]), 0);
            check($sformatf("mid-frame reset inst%0d adc_sample", i), int'(sample[i]), 0);
        end
        tick(3);
        rst = 1'b1;
        tick(250);

        check("scoreboard drained", exp_q.size(), 0);
        check("adc frames drained", adc_q.size(), 0);
        check("planned values used", plan_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
